// File: rtl/alu_sched_pkg.sv
//==============================================================================
// Module  : alu_sched_pkg
// Purpose : Shared types for the round-robin ALU scheduler.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_sched_pkg;

   localparam int DATA_W = 4;
   localparam int SEL_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef struct packed {
      logic [SEL_W-1:0]  sel;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } alu_op_t;

endpackage

`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
//==============================================================================
// Module  : alu_rr_arbiter
// Purpose : Combinational rotate-priority picker: first set request at or above ptr.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_rr_arbiter
   import alu_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   always_comb begin : p_pick
      logic found;
      int   j;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IDX_W'(j);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_rr_scheduler.sv
//==============================================================================
// Module  : alu_rr_scheduler
// Purpose : Round-robin sharing of one ALU between NUM_REQ requesters, one op in flight.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 4,
   parameter int SEL_W   = 3,
   parameter int ALU_LAT = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]   req_a,
   input  logic [NUM_REQ*DATA_W-1:0]   req_b,
   input  logic [NUM_REQ*SEL_W-1:0]    req_sel,
   output logic [NUM_REQ-1:0]          rsp_valid,
   input  logic [NUM_REQ-1:0]          rsp_ready,
   output logic [DATA_W-1:0]           rsp_result,
   output logic [DATA_W-1:0]           alu_A,
   output logic [DATA_W-1:0]           alu_B,
   output logic [SEL_W-1:0]            alu_sel,
   input  logic [DATA_W-1:0]           alu_Result,
   output logic                        busy
);
   import alu_sched_pkg::*;

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   state_e             r_state;
   state_e             w_state_nxt;
   logic [NUM_REQ-1:0] w_grant;
   logic [IDX_W-1:0]   w_grant_idx;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_id;
   logic [CNT_W-1:0]   r_cnt;
   logic [DATA_W-1:0]  r_alu_a;
   logic [DATA_W-1:0]  r_alu_b;
   logic [SEL_W-1:0]   r_alu_sel;
   logic [DATA_W-1:0]  r_result;
   logic               w_req_fire;
   logic               w_rsp_fire;
   logic               w_wait_done;

   alu_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (r_ptr),
      .grant (w_grant),
      .idx   (w_grant_idx)
   );

   assign w_req_fire  = (r_state == IDLE) && (|w_grant);
   assign w_rsp_fire  = (r_state == RESP) && rsp_ready[r_id];
   assign w_wait_done = (r_state == WAIT) && (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_req_fire)  w_state_nxt = ISSUE;
         ISSUE:                    w_state_nxt = WAIT;
         WAIT:    if (w_wait_done) w_state_nxt = RESP;
         RESP:    if (w_rsp_fire)  w_state_nxt = IDLE;
         default:                  w_state_nxt = IDLE;
      endcase
   end

   // The winner's operands go straight into the ALU-facing registers, so they
   // are on the pins from ISSUE onward and persist until the next grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr     <= '0;
         r_id      <= '0;
         r_cnt     <= '0;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_sel <= '0;
         r_result  <= '0;
      end else begin
         if (w_req_fire) begin
            r_id      <= w_grant_idx;
            r_ptr     <= (w_grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;
            r_alu_a   <= req_a[w_grant_idx*DATA_W +: DATA_W];
            r_alu_b   <= req_b[w_grant_idx*DATA_W +: DATA_W];
            r_alu_sel <= req_sel[w_grant_idx*SEL_W +: SEL_W];
         end
         if (r_state == ISSUE)
            r_cnt <= CNT_W'(ALU_LAT-1);
         else if ((r_state == WAIT) && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
         if (w_wait_done)
            r_result <= alu_Result;
         else if (w_rsp_fire)
            r_result <= '0;
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
      assign rsp_valid[i] = (r_state == RESP) && (r_id == IDX_W'(i));
   end

   assign req_ready  = (r_state == IDLE) ? w_grant : '0;
   assign busy       = (r_state != IDLE);
   assign alu_A      = r_alu_a;
   assign alu_B      = r_alu_b;
   assign alu_sel    = r_alu_sel;
   assign rsp_result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
//==============================================================================
// Module  : tb_alu_rr_scheduler
// Purpose : Self-checking bench for alu_rr_scheduler against a transaction-level model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_rr_scheduler;

   localparam int N   = 4;
   localparam int DW  = 4;
   localparam int SW  = 3;
   localparam int LAT = 1;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*DW-1:0] req_a;
   logic [N*DW-1:0] req_b;
   logic [N*SW-1:0] req_sel;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready;
   logic [DW-1:0]   rsp_result;
   logic [DW-1:0]   alu_A;
   logic [DW-1:0]   alu_B;
   logic [SW-1:0]   alu_sel;
   logic [DW-1:0]   alu_Result = '0;
   logic            busy;

   int checks = 0;
   int errors = 0;

   alu_rr_scheduler #(.NUM_REQ(N), .DATA_W(DW), .SEL_W(SW), .ALU_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel), .alu_Result(alu_Result),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] alu_fn(logic [DW-1:0] a, logic [DW-1:0] b, logic [SW-1:0] s);
      case (s)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         default: return a ^ b;
      endcase
   endfunction

   // Bench ALU with one cycle of latency.
   always @(posedge clk) alu_Result <= alu_fn(alu_A, alu_B, alu_sel);

   // Transaction-level model: one op in flight, response due 2+LAT cycles after grant.
   bit            m_inflight;
   int            m_age, m_owner, m_ptr, m_granted;
   logic [DW-1:0] m_a, m_b, m_res;
   logic [SW-1:0] m_sel;

   function automatic int pick(logic [N-1:0] v, int p);
      for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_model();
      int p;
      logic [N-1:0]  er, ev;
      logic [DW-1:0] eres;
      p    = pick(req_valid, m_ptr);
      er   = (!m_inflight && p >= 0) ? N'(1 << p) : '0;
      ev   = (m_inflight && m_age >= 2 + LAT) ? N'(1 << m_owner) : '0;
      eres = (ev != 0) ? m_res : '0;
      cmp("model.req_ready",  req_ready,  er);
      cmp("model.rsp_valid",  rsp_valid,  ev);
      cmp("model.rsp_result", rsp_result, eres);
      cmp("model.busy",       busy,       m_inflight);
      cmp("model.alu_A",      alu_A,      m_a);
      cmp("model.alu_B",      alu_B,      m_b);
      cmp("model.alu_sel",    alu_sel,    m_sel);
   endtask

   task automatic model_update();
      int p;
      m_granted = -1;
      if (reset) begin
         m_inflight = 0; m_age = 0; m_owner = 0; m_ptr = 0;
         m_a = '0; m_b = '0; m_sel = '0; m_res = '0;
      end else if (!m_inflight) begin
         p = pick(req_valid, m_ptr);
         if (p >= 0) begin
            m_granted  = p;
            m_inflight = 1;
            m_age      = 1;
            m_owner    = p;
            m_a        = req_a[p*DW +: DW];
            m_b        = req_b[p*DW +: DW];
            m_sel      = req_sel[p*SW +: SW];
            m_res      = alu_fn(m_a, m_b, m_sel);
            m_ptr      = (p + 1) % N;
         end
      end else if (m_age >= 2 + LAT && rsp_ready[m_owner]) begin
         m_inflight = 0;
      end else begin
         m_age++;
      end
   endtask

   task automatic step();
      #1;
      check_model();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic set_req(int idx, logic [DW-1:0] a, logic [DW-1:0] b, logic [SW-1:0] s);
      req_a[idx*DW +: DW]   = a;
      req_b[idx*DW +: DW]   = b;
      req_sel[idx*SW +: SW] = s;
   endtask

   task automatic run_op(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [SW-1:0] s, output logic [DW-1:0] res, output int lat);
      logic got;
      got = 1'b0; res = '0; lat = -1;
      set_req(idx, a, b, s);
      req_valid[idx] = 1'b1;
      for (int n = 0; n < 20 && !got; n++) begin
         #1;
         if (rsp_valid[idx]) begin got = 1'b1; res = rsp_result; lat = n; end
         step();
         if (m_granted == idx) req_valid[idx] = 1'b0;
      end
      req_valid[idx] = 1'b0;
      cmp("op_response_seen", got, 1);
   endtask

   function automatic int onehot_idx(logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] res;
      int            lat;
      int            gid[$];
      int            gcyc[$];
      bit            pend[N];

      reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = '1;
      @(posedge clk);
      model_update();
      @(posedge clk);
      model_update();
      @(negedge clk);
      reset = 1'b0;
      #1;
      cmp("reset_busy", busy, 0);
      cmp("reset_rsp_valid", rsp_valid, 0);
      cmp("reset_alu_A", alu_A, 0);
      cmp("reset_rsp_result", rsp_result, 0);

      // Single op with cycle-accurate latency.
      set_req(0, 4'd3, 4'd5, 3'd0);
      req_valid = 4'b0001;
      #1 cmp("t1_req_ready_c0", req_ready, 4'b0001);
      step();
      req_valid = '0;
      #1 cmp("t1_alu_A_c1", alu_A, 3);
      cmp("t1_alu_B_c1", alu_B, 5);
      step(); step();
      #1 cmp("t1_rsp_valid_c3", rsp_valid, 4'b0001);
      cmp("t1_rsp_result_c3", rsp_result, 8);
      step();

      // Modular wrap and subtraction.
      run_op(2, 4'd9, 4'd9, 3'd0, res, lat);
      cmp("t2_add_wrap", res, 2);
      cmp("t2_latency", lat, 3);
      run_op(0, 4'd2, 4'd5, 3'd1, res, lat);
      cmp("t2_sub_wrap", res, 13);

      // Round-robin with everyone valid.
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, DW'(i), DW'(i + 1), 3'd0);
      req_valid = '1;
      for (int c = 0; c < 17; c++) begin
         #1;
         if (req_ready != 0) begin gid.push_back(onehot_idx(req_ready)); gcyc.push_back(c); end
         step();
      end
      req_valid = '0;
      cmp("t3_grant_count", gid.size() >= 5, 1);
      if (gid.size() >= 5) begin
         cmp("t3_order0", gid[0], 0);
         cmp("t3_order1", gid[1], 1);
         cmp("t3_order2", gid[2], 2);
         cmp("t3_order3", gid[3], 3);
         cmp("t3_order4", gid[4], 0);
         for (int k = 0; k < 4; k++) cmp("t3_spacing", gcyc[k+1] - gcyc[k], 4);
      end
      repeat (4) step();

      // Backpressure on requester 1; other rsp_ready bits high and ignored.
      do_reset();
      set_req(1, 4'd7, 4'd1, 3'd0);
      req_valid = 4'b0010;
      rsp_ready = 4'b1101;
      step();
      req_valid = 4'b1101;
      step(); step();
      for (int k = 0; k < 5; k++) begin
         #1;
         cmp("t4_rsp_valid_held", rsp_valid, 4'b0010);
         cmp("t4_rsp_result_held", rsp_result, 8);
         cmp("t4_req_ready_low", req_ready, 0);
         step();
      end
      rsp_ready = '1;
      step();
      req_valid = '0;
      #1 cmp("t4_idle_busy", busy, 0);
      cmp("t4_idle_rsp_valid", rsp_valid, 0);
      cmp("t4_idle_rsp_result", rsp_result, 0);
      step();

      // Reset during WAIT drops the op.
      do_reset();
      set_req(3, 4'd4, 4'd4, 3'd2);
      req_valid = 4'b1000;
      step();
      req_valid = '0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      cmp("t5_busy", busy, 0);
      cmp("t5_rsp_valid", rsp_valid, 0);
      cmp("t5_alu_A", alu_A, 0);
      cmp("t5_alu_B", alu_B, 0);
      cmp("t5_alu_sel", alu_sel, 0);
      cmp("t5_rsp_result", rsp_result, 0);
      req_valid = '1;
      #1 cmp("t5_first_grant_req0", req_ready, 4'b0001);
      step();
      req_valid = '0;
      repeat (4) step();

      // Pointer skip: after granting 1, pointer sits at 2.
      do_reset();
      run_op(1, 4'd1, 4'd1, 3'd0, res, lat);
      set_req(0, 4'd6, 4'd2, 3'd1);
      set_req(3, 4'd5, 4'd3, 3'd2);
      req_valid = 4'b1001;
      gid.delete();
      for (int c = 0; c < 20 && gid.size() < 2; c++) begin
         #1;
         if (req_ready != 0) gid.push_back(onehot_idx(req_ready));
         step();
      end
      req_valid = '0;
      cmp("t6_grant_count", gid.size(), 2);
      if (gid.size() == 2) begin
         cmp("t6_first_req3", gid[0], 3);
         cmp("t6_second_req0", gid[1], 0);
      end
      repeat (4) step();

      // Randomized traffic with random backpressure and occasional reset.
      do_reset();
      for (int i = 0; i < N; i++) pend[i] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1;
               set_req(i, DW'($urandom), DW'($urandom), SW'($urandom_range(0, 3)));
            end else if (pend[i] && $urandom_range(0, 24) == 0) begin
               pend[i] = 0;
            end
            req_valid[i] = pend[i];
         end
         rsp_ready = N'($urandom);
         reset     = ($urandom_range(0, 499) == 0);
         step();
         if (m_granted >= 0) pend[m_granted] = 0;
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
